// File: rtl/cic_interpolator.sv
// -----------------------------------------------------------------------------
// cic_interpolator
//
// Transmit-side CIC interpolator at the head of the DUC chain. Each accepted
// input sample is differentiated by a Q-stage comb at the input rate. It is
// then zero-stuffed to R output phases and integrated by Q integrators at the
// output rate. Finally it is rescaled by the CIC gain, rounded and saturated
// back to DATA_WIDTH.
//
// Ports
//   clk         clock
//   rst         asynchronous active-high reset
//   valid_in    cic_in valid
//   ready_in    block can accept cic_in this cycle
//   bypass      1 = pass cic_in straight to cic_out through one register
//   int_factor  interpolation factor R (1,2,4,8,16; anything else acts as 1)
//   cic_in      signed input sample, Q1.DATA_FRAC
//   valid_out   cic_out valid, one per output-rate sample
//   cic_out     signed interpolated sample, Q1.DATA_FRAC
//   overflow    1-cycle pulse with valid_out when cic_out was clipped high
//   underflow   1-cycle pulse with valid_out when cic_out was clipped low
// -----------------------------------------------------------------------------
module cic_interpolator #(
  parameter  int DATA_WIDTH     = 16,
  parameter  int DATA_FRAC      = 15,
  parameter  int Q              = 1,
  parameter  int N              = 1,
  localparam int MAX_INT_FACTOR = 16,
  localparam int INT_WIDTH      = $clog2(MAX_INT_FACTOR)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  output logic                         ready_in,
  input  logic                         bypass,
  input  logic [INT_WIDTH:0]           int_factor,
  input  logic signed [DATA_WIDTH-1:0] cic_in,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] cic_out,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int LOG2N = $clog2(N);
  // Internal width covers the full CIC bit growth, so the integrators may wrap
  // freely and still produce the correct result modulo 2^W.
  localparam int W     = DATA_WIDTH + Q * (LOG2N + INT_WIDTH);
  localparam int RLW   = $clog2(INT_WIDTH + 1);

  localparam logic signed [W:0] SAT_MAX =
    {{(W - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN =
    {{(W - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  if (Q < 1 || Q > 4) begin : g_bad_q
    $error("cic_interpolator: Q must be in 1..4");
  end
  if (N != 1 && N != 2) begin : g_bad_n
    $error("cic_interpolator: N must be 1 or 2");
  end
  if (DATA_FRAC >= DATA_WIDTH) begin : g_bad_frac
    $error("cic_interpolator: DATA_FRAC must be below DATA_WIDTH");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  // log2 of a legal factor; illegal factors collapse to R=1 (log2 = 0).
  function automatic logic [RLW-1:0] decode_r(input logic [INT_WIDTH:0] f);
    logic [RLW-1:0] r;
    r = '0;
    for (int i = 0; i <= INT_WIDTH; i++) begin
      if (f == (INT_WIDTH + 1)'(1 << i)) r = RLW'(i);
    end
    return r;
  endfunction

  // Arithmetic right shift with round half-up, one guard bit against wrap.
  function automatic logic signed [W:0] round_shift(input logic signed [W-1:0] acc,
                                                    input logic [7:0]          s);
    logic signed [W:0] ext;
    ext = {acc[W-1], acc};
    if (s != 8'd0) ext = ext + $signed((W + 1)'(1) << (s - 8'd1));
    return ext >>> s;
  endfunction

  // Returns {overflow, underflow, clipped sample}.
  function automatic logic [DATA_WIDTH+1:0] saturate(input logic signed [W:0] v);
    logic [DATA_WIDTH+1:0] r;
    if (v > SAT_MAX) begin
      r = {2'b10, 1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {2'b01, 1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end else begin
      r = {2'b00, v[DATA_WIDTH-1:0]};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Control: handshake and phase FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [INT_WIDTH-1:0] phase, phase_nxt;
  logic [RLW-1:0]       r_log2;
  logic [RLW-1:0]       r_log2_in;
  logic [INT_WIDTH-1:0] r_last;
  logic                 at_last;
  logic                 accept;
  logic                 r_change;

  assign r_log2_in = decode_r(int_factor);
  assign r_last    = INT_WIDTH'((1 << r_log2) - 1);
  assign at_last   = (state == RUN) && (phase == r_last);
  assign ready_in  = bypass | (state == IDLE) | at_last;
  assign accept    = valid_in & ready_in & ~bypass;
  // A new effective R invalidates the filter memory built up under the old one.
  assign r_change  = accept & (r_log2_in != r_log2);

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = RUN;
          phase_nxt = '0;
        end
      end
      RUN: begin
        if (at_last) begin
          phase_nxt = '0;
          if (!accept) state_nxt = IDLE;
        end else begin
          phase_nxt = phase + INT_WIDTH'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      phase  <= '0;
      r_log2 <= '0;
    end else if (bypass) begin
      state  <= IDLE;
      phase  <= '0;
      r_log2 <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      if (accept) r_log2 <= r_log2_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p0: comb cascade at input rate into the hold register
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] comb_c [0:Q];
  logic signed [W-1:0] dly    [0:Q-1][0:N-1];
  logic signed [W-1:0] hold_p0;

  always_comb begin
    comb_c[0] = {{(W - DATA_WIDTH){cic_in[DATA_WIDTH-1]}}, cic_in};
    for (int k = 0; k < Q; k++) begin
      // On an R change the delay lines read as empty for this sample too.
      comb_c[k+1] = comb_c[k] - (r_change ? '0 : dly[k][N-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_p0 <= '0;
      for (int k = 0; k < Q; k++)
        for (int j = 0; j < N; j++) dly[k][j] <= '0;
    end else if (bypass) begin
      hold_p0 <= '0;
      for (int k = 0; k < Q; k++)
        for (int j = 0; j < N; j++) dly[k][j] <= '0;
    end else if (accept) begin
      hold_p0 <= comb_c[Q];
      for (int k = 0; k < Q; k++) begin
        dly[k][0] <= comb_c[k];
        for (int j = 1; j < N; j++) dly[k][j] <= r_change ? '0 : dly[k][j-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: zero-stuff; stage p2: integrator cascade at output rate
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] zs_p1;
  logic                vld_p1;
  logic signed [W-1:0] integ_p2 [0:Q-1];
  logic [Q-1:0]        vld_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zs_p1  <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= '0;
      for (int k = 0; k < Q; k++) integ_p2[k] <= '0;
    end else if (bypass) begin
      zs_p1  <= '0;
      vld_p1 <= 1'b0;
      vld_p2 <= '0;
      for (int k = 0; k < Q; k++) integ_p2[k] <= '0;
    end else begin
      vld_p1    <= (state == RUN);
      zs_p1     <= ((state == RUN) && (phase == '0)) ? hold_p0 : '0;
      vld_p2[0] <= vld_p1;
      for (int k = 1; k < Q; k++) vld_p2[k] <= vld_p2[k-1];
      if (r_change) begin
        for (int k = 0; k < Q; k++) integ_p2[k] <= '0;
      end else begin
        // Each stage advances only when its input carries a phase token, so
        // idle gaps leave the integrators untouched.
        if (vld_p1) integ_p2[0] <= integ_p2[0] + zs_p1;
        for (int k = 1; k < Q; k++) begin
          if (vld_p2[k-1]) integ_p2[k] <= integ_p2[k] + integ_p2[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: gain removal (shift by (Q-1)*log2R + Q*log2N), round, clip
  // ---------------------------------------------------------------------------
  logic [7:0]            shift_s;
  logic [DATA_WIDTH+1:0] sat_word;

  assign shift_s  = 8'((Q - 1) * int'(r_log2) + Q * LOG2N);
  assign sat_word = saturate(round_shift(integ_p2[Q-1], shift_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      cic_out   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bypass) begin
      valid_out <= valid_in;
      cic_out   <= cic_in;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid_out <= vld_p2[Q-1];
      if (vld_p2[Q-1]) begin
        cic_out   <= sat_word[DATA_WIDTH-1:0];
        overflow  <= sat_word[DATA_WIDTH+1];
        underflow <= sat_word[DATA_WIDTH];
      end else begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
    end
  end

endmodule
